// File: rtl/usb_tx_pkg.sv
// -----------------------------------------------------------------------------
// usb_tx_pkg
// Shared definitions for the USB transmit line encoder:
//   - default bit timing and bit-stuffing limit
//   - bus line-state encodings {d_plus, d_minus}
//   - transmit FSM state enum
//   - NRZI level-to-line helper
// -----------------------------------------------------------------------------
package usb_tx_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 8;
  localparam int STUFF_LIMIT_DEFAULT  = 6;

  // Line state as driven on {d_plus, d_minus}.
  typedef logic [1:0] line_t;

  localparam line_t LINE_J   = 2'b10;
  localparam line_t LINE_K   = 2'b01;
  localparam line_t LINE_SE0 = 2'b00;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_DATA  = 3'd1,
    TX_STUFF = 3'd2,
    TX_SE0   = 3'd3,
    TX_J     = 3'd4
  } tx_state_e;

  // The NRZI level register holds 1 for J and 0 for K.
  function automatic line_t nrzi_line(input logic level);
    return level ? LINE_J : LINE_K;
  endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// -----------------------------------------------------------------------------
// usb_bit_timer
// Wrap counter 0..CLKS_PER_BIT-1 that paces one USB bit period.
// Ports:
//   clk, n_rst  : clock, asynchronous active-low reset
//   i_clear     : synchronous clear to 0 (has priority over i_enable)
//   i_enable    : count enable
//   o_start     : counter is 0 (first clock of a bit period)
//   o_tc        : terminal count while enabled (last clock of a bit period)
// -----------------------------------------------------------------------------
module usb_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_start,
  output logic o_tc
);

  localparam int             CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  // NOTE: clocked state is always written with non-blocking assignments so
  // every register samples its inputs from before the edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= (r_count == LAST) ? '0 : r_count + CW'(1);
    end
  end

  assign o_start = (r_count == '0);
  assign o_tc    = i_enable && (r_count == LAST);

endmodule

// File: rtl/usb_tx_line_encoder.sv
// -----------------------------------------------------------------------------
// usb_tx_line_encoder
// Serializes bytes from the transmit control unit onto the USB pair with
// LSB-first shifting, bit stuffing and NRZI encoding, and generates EOP.
// Ports:
//   clk, n_rst     : clock, asynchronous active-low reset
//   sending        : control unit owns the bus; low aborts to idle
//   data[7:0]      : next byte, latched only at a reload
//   load_enable_g  : forced load of data, starts (or restarts) a packet
//   eop            : drive SE0 for the bit period starting now
//   eop_special    : drive J for the bit period starting now
//   shift_enable   : last clock of every bit period
//   load_enable    : byte finished (after any trailing stuff bit), data latched
//   crc_bit        : unstuffed data bit currently being sent
//   crc_shift      : strobe for crc_bit, data bits only
//   d_plus/d_minus : registered bus pair
// -----------------------------------------------------------------------------
module usb_tx_line_encoder
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int STUFF_LIMIT  = STUFF_LIMIT_DEFAULT
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sending,
  input  logic [7:0] data,
  input  logic       load_enable_g,
  input  logic       eop,
  input  logic       eop_special,
  output logic       shift_enable,
  output logic       load_enable,
  output logic       crc_bit,
  output logic       crc_shift,
  output logic       d_plus,
  output logic       d_minus
);

  localparam int            OW        = $clog2(STUFF_LIMIT + 1);
  localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LIMIT);

  tx_state_e     r_state;
  logic [7:0]    r_shreg;
  logic [2:0]    r_bit_cnt;
  logic [OW-1:0] r_ones;
  logic          r_level;    // NRZI level, 1 = J
  logic          r_pending;  // byte ended on a stuffed bit, reload deferred
  line_t         r_line;

  logic          w_start;
  logic          w_tc;
  logic          w_active;
  logic          w_clear;
  logic          w_shift;
  logic          w_bit;
  logic [OW-1:0] w_ones_next;
  logic          w_stuff_now;
  logic          w_last_bit;

  assign w_active = (r_state != TX_IDLE);
  // Timer restarts on idle, abort, and any forced load so the first bit
  // boundary always follows a load by exactly one clock.
  assign w_clear  = !w_active || !sending || load_enable_g;

  usb_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_clear  (w_clear),
    .i_enable (w_active),
    .o_start  (w_start),
    .o_tc     (w_tc)
  );

  // No strobes in a cycle that aborts or restarts the packet.
  assign w_shift     = w_tc && sending && !load_enable_g;
  assign w_bit       = r_shreg[0];
  assign w_ones_next = w_bit ? r_ones + OW'(1) : '0;
  assign w_stuff_now = (w_ones_next == STUFF_MAX);
  assign w_last_bit  = (r_bit_cnt == 3'd7);

  assign shift_enable = w_shift;
  assign crc_shift    = w_shift && (r_state == TX_DATA);
  assign crc_bit      = r_shreg[0];
  assign load_enable  = w_shift &&
                        (((r_state == TX_DATA)  && !w_stuff_now && w_last_bit) ||
                         ((r_state == TX_STUFF) && r_pending));

  assign d_plus  = r_line[1];
  assign d_minus = r_line[0];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= TX_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_ones    <= '0;
      r_level   <= 1'b1;
      r_pending <= 1'b0;
      r_line    <= LINE_J;
    end else if (!sending && w_active) begin
      // Abort: back to idle J with all counters cleared.
      r_state   <= TX_IDLE;
      r_bit_cnt <= '0;
      r_ones    <= '0;
      r_level   <= 1'b1;
      r_pending <= 1'b0;
      r_line    <= LINE_J;
    end else if (load_enable_g) begin
      r_state   <= TX_DATA;
      r_shreg   <= data;
      r_bit_cnt <= '0;
      r_ones    <= '0;
      r_level   <= 1'b1;
      r_pending <= 1'b0;
      r_line    <= LINE_J;
    end else if (!w_active) begin
      r_bit_cnt <= '0;
      r_ones    <= '0;
      r_line    <= LINE_J;
    end else if (w_start) begin
      // Bit boundary: choose the symbol for the whole period.
      if (eop) begin
        r_state <= TX_SE0;
        r_line  <= LINE_SE0;
      end else if (eop_special) begin
        r_state <= TX_J;
        r_level <= 1'b1;
        r_line  <= LINE_J;
      end else begin
        case (r_state)
          TX_DATA: begin
            // NRZI: a 0 toggles the level, a 1 holds it.
            if (!w_bit) r_level <= ~r_level;
            r_line <= nrzi_line(w_bit ? r_level : ~r_level);
          end
          TX_STUFF: begin
            r_level <= ~r_level;
            r_line  <= nrzi_line(~r_level);
          end
          TX_SE0: begin
            // SE0 released without eop_special: finish the EOP on J anyway.
            r_state <= TX_J;
            r_level <= 1'b1;
            r_line  <= LINE_J;
          end
          default: begin
            r_line <= LINE_J;
          end
        endcase
      end
    end else if (w_shift) begin
      case (r_state)
        TX_DATA: begin
          r_ones <= w_ones_next;
          if (w_stuff_now) begin
            r_state   <= TX_STUFF;
            r_shreg   <= {1'b0, r_shreg[7:1]};
            // A stuff after the 8th bit postpones the byte end by one period.
            r_pending <= w_last_bit;
            if (!w_last_bit) r_bit_cnt <= r_bit_cnt + 3'd1;
          end else if (w_last_bit) begin
            r_shreg   <= data;
            r_bit_cnt <= '0;
          end else begin
            r_shreg   <= {1'b0, r_shreg[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        TX_STUFF: begin
          r_state <= TX_DATA;
          r_ones  <= '0;
          if (r_pending) begin
            r_shreg   <= data;
            r_bit_cnt <= '0;
            r_pending <= 1'b0;
          end
        end
        default: begin
          // SE0 and J periods carry no data.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// -----------------------------------------------------------------------------
// tb_usb_tx_line_encoder
// Directed bench for usb_tx_line_encoder. Each test task drives a scenario
// and compares per-bit-period observations against hand-derived sequences.
// -----------------------------------------------------------------------------
module tb_usb_tx_line_encoder;

  localparam int         CPB = 8;
  localparam int         SL  = 6;
  localparam logic [1:0] LJ  = 2'b10;
  localparam logic [1:0] LK  = 2'b01;
  localparam logic [1:0] LS  = 2'b00;

  logic       clk           = 1'b0;
  logic       n_rst         = 1'b0;
  logic       sending       = 1'b0;
  logic [7:0] data          = 8'h00;
  logic       load_enable_g = 1'b0;
  logic       eop           = 1'b0;
  logic       eop_special   = 1'b0;
  logic       shift_enable;
  logic       load_enable;
  logic       crc_bit;
  logic       crc_shift;
  logic       d_plus;
  logic       d_minus;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  usb_tx_line_encoder #(
    .CLKS_PER_BIT (CPB),
    .STUFF_LIMIT  (SL)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .sending       (sending),
    .data          (data),
    .load_enable_g (load_enable_g),
    .eop           (eop),
    .eop_special   (eop_special),
    .shift_enable  (shift_enable),
    .load_enable   (load_enable),
    .crc_bit       (crc_bit),
    .crc_shift     (crc_shift),
    .d_plus        (d_plus),
    .d_minus       (d_minus)
  );

  // Forced load of b0; b1 is presented as the next byte right afterwards.
  // Returns in the first clock of bit period 0 (timer = 0).
  task automatic start_packet(input logic [7:0] b0, input logic [7:0] b1);
    @(posedge clk); #1;
    sending       = 1'b1;
    data          = b0;
    load_enable_g = 1'b1;
    @(posedge clk); #1;
    load_enable_g = 1'b0;
    data          = b1;
  endtask

  task automatic end_packet();
    sending     = 1'b0;
    eop         = 1'b0;
    eop_special = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Observes one bit period starting in its timer = 0 clock; returns in the
  // timer = 0 clock of the next period.
  task automatic run_period(output logic [1:0] line, output bit stable,
                            output int n_se, output int n_le, output int n_cs,
                            output logic cb);
    line   = 2'bxx;
    stable = 1'b1;
    n_se   = 0;
    n_le   = 0;
    n_cs   = 0;
    cb     = 1'bx;
    for (int j = 0; j < CPB; j++) begin
      @(negedge clk);
      if (j == 1) line = {d_plus, d_minus};
      else if (j > 1 && {d_plus, d_minus} !== line) stable = 1'b0;
      if (shift_enable === 1'b1) n_se++;
      if (load_enable === 1'b1) n_le++;
      if (crc_shift === 1'b1) begin
        n_cs++;
        cb = crc_bit;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    int bad;
    #12;
    checks++;
    if ({d_plus, d_minus} !== LJ) begin
      failures++;
      $display("FAIL reset_line got=%b exp=%b", {d_plus, d_minus}, LJ);
    end
    checks++;
    if ({shift_enable, load_enable, crc_shift, crc_bit} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=0000",
               {shift_enable, load_enable, crc_shift, crc_bit});
    end
    @(negedge clk);
    n_rst = 1'b1;
    // Byte 0x00 toggles every bit: K J K; stop on period 2's last clock.
    start_packet(8'h00, 8'h00);
    repeat (2 * CPB + CPB - 1) begin @(posedge clk); #1; end
    checks++;
    if (shift_enable !== 1'b1 || {d_plus, d_minus} !== LK) begin
      failures++;
      $display("FAIL pre_reset got se=%b line=%b exp se=1 line=%b",
               shift_enable, {d_plus, d_minus}, LK);
    end
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({d_plus, d_minus} !== LJ) begin
      failures++;
      $display("FAIL midreset_line got=%b exp=%b", {d_plus, d_minus}, LJ);
    end
    checks++;
    if ({shift_enable, load_enable, crc_shift, crc_bit} !== 4'b0000) begin
      failures++;
      $display("FAIL midreset_strobes got=%b exp=0000",
               {shift_enable, load_enable, crc_shift, crc_bit});
    end
    @(negedge clk);
    n_rst = 1'b1;
    bad = 0;
    repeat (3 * CPB) begin
      @(negedge clk);
      if ({d_plus, d_minus} !== LJ ||
          {shift_enable, load_enable, crc_shift} !== 3'b000) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL post_reset_idle got=%0d busy clocks exp=0", bad);
    end
    end_packet();
  endtask

  task automatic test_sync();
    logic [1:0] exp [8] = '{LK, LJ, LK, LJ, LK, LJ, LK, LK};
    logic [7:0] byte_v = 8'h80;
    logic [1:0] line;
    bit         stable;
    int         n_se, n_le, n_cs, exp_le;
    logic       cb;
    start_packet(8'h80, 8'h00);
    for (int p = 0; p < 8; p++) begin
      run_period(line, stable, n_se, n_le, n_cs, cb);
      exp_le = (p == 7) ? 1 : 0;
      checks++;
      if (line !== exp[p] || !stable) begin
        failures++;
        $display("FAIL sync_line p=%0d got=%b stable=%0b exp=%b", p, line, stable, exp[p]);
      end
      checks++;
      if (n_se != 1 || n_cs != 1 || n_le != exp_le) begin
        failures++;
        $display("FAIL sync_strobes p=%0d got se=%0d le=%0d cs=%0d exp se=1 le=%0d cs=1",
                 p, n_se, n_le, n_cs, exp_le);
      end
      checks++;
      if (cb !== byte_v[p]) begin
        failures++;
        $display("FAIL sync_crc_bit p=%0d got=%b exp=%b", p, cb, byte_v[p]);
      end
    end
    end_packet();
  endtask

  task automatic test_stuffing();
    logic [1:0] exp [18] = '{LJ, LJ, LJ, LJ, LJ, LJ,
                             LK, LK, LK, LK, LK, LK, LK,
                             LJ, LJ, LJ, LJ, LJ};
    logic [1:0] line;
    bit         stable;
    int         n_se, n_le, n_cs, exp_le, exp_cs;
    logic       cb;
    start_packet(8'hFF, 8'hFF);
    for (int p = 0; p < 18; p++) begin
      run_period(line, stable, n_se, n_le, n_cs, cb);
      exp_le = (p == 8 || p == 17) ? 1 : 0;
      exp_cs = (p == 6 || p == 13) ? 0 : 1;
      checks++;
      if (line !== exp[p] || !stable) begin
        failures++;
        $display("FAIL stuff_line p=%0d got=%b stable=%0b exp=%b", p, line, stable, exp[p]);
      end
      checks++;
      if (n_se != 1 || n_cs != exp_cs || n_le != exp_le) begin
        failures++;
        $display("FAIL stuff_strobes p=%0d got se=%0d le=%0d cs=%0d exp se=1 le=%0d cs=%0d",
                 p, n_se, n_le, n_cs, exp_le, exp_cs);
      end
      if (exp_cs == 1) begin
        checks++;
        if (cb !== 1'b1) begin
          failures++;
          $display("FAIL stuff_crc_bit p=%0d got=%b exp=1", p, cb);
        end
      end
    end
    end_packet();
  endtask

  // Bytes 0x00, 0x3F, 0xFC then EOP. 0x3F stuffs mid-byte; 0xFC ends on
  // six 1s, so its stuffed 0 comes before load_enable and before SE0.
  task automatic test_trailing_stuff_eop();
    logic [1:0] exp [29] = '{LK, LJ, LK, LJ, LK, LJ, LK, LJ,
                             LJ, LJ, LJ, LJ, LJ, LJ,
                             LK,
                             LJ, LK,
                             LJ, LK,
                             LK, LK, LK, LK, LK, LK,
                             LJ,
                             LS, LS,
                             LJ};
    logic [1:0] line;
    bit         stable;
    int         n_se, n_le, n_cs, exp_le, exp_cs;
    logic       cb, exp_cb;
    start_packet(8'h00, 8'h3F);
    for (int p = 0; p < 29; p++) begin
      if (p == 8)  data = 8'hFC;
      if (p == 17) data = 8'h00;
      if (p == 26) eop  = 1'b1;
      if (p == 28) begin
        eop         = 1'b0;
        eop_special = 1'b1;
      end
      run_period(line, stable, n_se, n_le, n_cs, cb);
      exp_le = (p == 7 || p == 16 || p == 25) ? 1 : 0;
      exp_cs = (p < 25 && p != 14) ? 1 : 0;
      exp_cb = ((p >= 8 && p <= 13) || (p >= 19 && p <= 24)) ? 1'b1 : 1'b0;
      checks++;
      if (line !== exp[p] || !stable) begin
        failures++;
        $display("FAIL trail_line p=%0d got=%b stable=%0b exp=%b", p, line, stable, exp[p]);
      end
      checks++;
      if (n_se != 1 || n_cs != exp_cs || n_le != exp_le) begin
        failures++;
        $display("FAIL trail_strobes p=%0d got se=%0d le=%0d cs=%0d exp se=1 le=%0d cs=%0d",
                 p, n_se, n_le, n_cs, exp_le, exp_cs);
      end
      if (exp_cs == 1) begin
        checks++;
        if (cb !== exp_cb) begin
          failures++;
          $display("FAIL trail_crc_bit p=%0d got=%b exp=%b", p, cb, exp_cb);
        end
      end
    end
    end_packet();
  endtask

  task automatic test_abort();
    logic [1:0] exp3 [3] = '{LK, LJ, LK};
    logic [1:0] exps [8] = '{LK, LJ, LK, LJ, LK, LJ, LK, LK};
    logic [1:0] line;
    bit         stable;
    int         n_se, n_le, n_cs, exp_le, bad;
    logic       cb;
    // 0x08: bits 0..2 are 0 (K J K), bit 3 is 1 (holds K).
    start_packet(8'h08, 8'h00);
    for (int p = 0; p < 3; p++) begin
      run_period(line, stable, n_se, n_le, n_cs, cb);
      checks++;
      if (line !== exp3[p] || !stable) begin
        failures++;
        $display("FAIL abort_pre_line p=%0d got=%b exp=%b", p, line, exp3[p]);
      end
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ({d_plus, d_minus} !== LK) begin
      failures++;
      $display("FAIL abort_bit3_line got=%b exp=%b", {d_plus, d_minus}, LK);
    end
    sending = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({d_plus, d_minus} !== LJ) begin
      failures++;
      $display("FAIL abort_line got=%b exp=%b", {d_plus, d_minus}, LJ);
    end
    bad = 0;
    repeat (3 * CPB) begin
      @(negedge clk);
      if ({d_plus, d_minus} !== LJ ||
          {shift_enable, load_enable, crc_shift} !== 3'b000) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL abort_idle got=%0d busy clocks exp=0", bad);
    end
    start_packet(8'h80, 8'h00);
    for (int p = 0; p < 8; p++) begin
      run_period(line, stable, n_se, n_le, n_cs, cb);
      exp_le = (p == 7) ? 1 : 0;
      checks++;
      if (line !== exps[p] || !stable || n_se != 1 || n_le != exp_le) begin
        failures++;
        $display("FAIL restart p=%0d got line=%b se=%0d le=%0d exp line=%b se=1 le=%0d",
                 p, line, n_se, n_le, exps[p], exp_le);
      end
    end
    end_packet();
  endtask

  initial begin
    test_reset();
    test_sync();
    test_stuffing();
    test_trailing_stuff_eop();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
